// File: rtl/core_dispatch_scheduler_if.sv
// core_dispatch_scheduler_if: host/core handshake bundle for the dispatch scheduler.
interface core_dispatch_scheduler_if #(parameter int CORE_NUM = 4);
  logic                start;
  logic [CORE_NUM-1:0] core_en;
  logic [CORE_NUM-1:0] core_done;
  logic                clear_interrupt;
  logic [CORE_NUM-1:0] core_start;
  logic                busy;
  logic                interrupt;
  logic [CORE_NUM-1:0] done_mask;
  logic                timeout;
  modport master (output start, core_en, core_done, clear_interrupt,
                  input  core_start, busy, interrupt, done_mask, timeout);
  modport slave  (input  start, core_en, core_done, clear_interrupt,
                  output core_start, busy, interrupt, done_mask, timeout);
endinterface

// File: rtl/core_dispatch_scheduler.sv
// core_dispatch_scheduler: launches enabled cores one slot per cycle, waits for completion, raises interrupt.
// Optional watchdog abort enabled by defining SCHED_WATCHDOG_EN.
module core_dispatch_scheduler #(
  parameter int CORE_NUM = 4,
  parameter int TIMEOUT  = 1024
) (
  input logic clk,
  input logic reset,
  core_dispatch_scheduler_if.slave bus
);
  localparam int SW = CORE_NUM > 1 ? $clog2(CORE_NUM) : 1;
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, DONE} state_t;
  state_t              r_state, w_next;
  logic [CORE_NUM-1:0] r_active, r_done_mask, w_one, w_launched, w_done_acc;
  logic [SW-1:0]       r_slot;
  logic                r_interrupt, r_timeout;
  logic                w_last, w_all_done, w_complete, w_wd_hit, w_run;
  assign w_one      = CORE_NUM'(1) << r_slot;
  assign w_last     = r_slot == SW'(CORE_NUM - 1);
  assign w_run      = r_state == DISPATCH || r_state == WAIT;
  assign w_all_done = (r_done_mask & r_active) == r_active;
  assign w_complete = w_all_done && (r_state == WAIT || (r_state == DISPATCH && w_last));
  // a core counts as launched once its slot has passed, so only earlier slots accept done
  assign w_launched = r_state == WAIT ? {CORE_NUM{1'b1}} :
                      r_state == DISPATCH ? w_one - CORE_NUM'(1) : {CORE_NUM{1'b0}};
  assign w_done_acc = bus.core_done & r_active & w_launched;
`ifdef SCHED_WATCHDOG_EN
  logic [15:0] r_wdog;
  assign w_wd_hit = w_run && r_wdog == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_wdog <= '0;
    else       r_wdog <= w_run ? r_wdog + 16'd1 : 16'd0;
`else
  assign w_wd_hit = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = !bus.start ? IDLE : bus.core_en == '0 ? DONE : DISPATCH;
      DISPATCH: w_next = w_complete || w_wd_hit ? DONE : w_last ? WAIT : DISPATCH;
      WAIT:     w_next = w_complete || w_wd_hit ? DONE : WAIT;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_done_mask <= '0;
      r_slot      <= '0;
      r_interrupt <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_interrupt <= r_state == DONE || (r_interrupt && !bus.clear_interrupt);
      if (r_state == IDLE && bus.start) begin
        r_active    <= bus.core_en;
        r_done_mask <= '0;
        r_timeout   <= 1'b0;
        r_slot      <= '0;
      end else begin
        r_done_mask <= r_done_mask | w_done_acc;
        if (r_state == DISPATCH && !w_last) r_slot <= r_slot + SW'(1);
        if (w_wd_hit && !w_complete) r_timeout <= 1'b1;
      end
    end
  end
  assign bus.core_start = r_state == DISPATCH ? w_one & r_active : '0;
  assign bus.busy       = r_state != IDLE;
  assign bus.interrupt  = r_interrupt;
  assign bus.done_mask  = r_done_mask;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_core_dispatch_scheduler.sv
// tb_core_dispatch_scheduler: directed scenarios plus random traffic against a run-level reference model.
module tb_core_dispatch_scheduler;
  localparam int N = 4;
`ifdef SCHED_WATCHDOG_EN
  localparam int TO = 16;
  localparam bit WD = 1'b1;
`else
  localparam int TO = 1024;
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  core_dispatch_scheduler_if #(.CORE_NUM(N)) bus ();
  core_dispatch_scheduler #(.CORE_NUM(N), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // run model: m_k counts cycles since the accepted start, m_in_done marks the single completion cycle
  logic         m_busy, m_in_done, m_irq, m_to;
  logic [N-1:0] m_act, m_dm;
  int           m_k;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_busy = 0; m_in_done = 0; m_irq = 0; m_to = 0; m_act = '0; m_dm = '0; m_k = 0;
  endtask
  task automatic check_outputs();
    logic [N-1:0] e_cs;
    e_cs = '0;
    if (m_busy && !m_in_done && m_k >= 1 && m_k <= N)
      if (m_act[m_k-1]) e_cs = N'(1) << (m_k - 1);
    chk("core_start", 32'(bus.core_start), 32'(e_cs));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("interrupt", 32'(bus.interrupt), 32'(m_irq));
    chk("done_mask", 32'(bus.done_mask), 32'(m_dm));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
  endtask
  task automatic m_update(input logic s, input logic [N-1:0] en, input logic [N-1:0] d, input logic c);
    logic was_done;
    logic [N-1:0] old_dm;
    was_done = m_in_done;
    old_dm = m_dm;
    m_irq = was_done ? 1'b1 : (c ? 1'b0 : m_irq);
    if (!m_busy) begin
      if (s) begin
        m_act = en; m_dm = '0; m_to = 0; m_k = 1; m_busy = 1; m_in_done = (en == '0);
      end
    end else if (was_done) begin
      m_busy = 0; m_k = 0; m_in_done = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (m_act[i] && d[i] && m_k > i + 1) m_dm[i] = 1'b1;
      if (m_k >= N && (old_dm & m_act) == m_act) m_in_done = 1;
      else if (WD && m_k == TO) begin m_to = 1; m_in_done = 1; end
      else m_k++;
    end
  endtask
  task automatic step(input logic s, input logic [N-1:0] en, input logic [N-1:0] d, input logic c);
    @(negedge clk);
    bus.start = s; bus.core_en = en; bus.core_done = d; bus.clear_interrupt = c;
    #1 check_outputs();
    @(posedge clk);
    m_update(s, en, d, c);
  endtask
  task automatic mid_reset();
    @(negedge clk);
    bus.start = 0; bus.core_done = '0; bus.clear_interrupt = 0;
    #2 reset = 1;
    #1;
    chk("rst_core_start", 32'(bus.core_start), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_interrupt", 32'(bus.interrupt), 0);
    chk("rst_done_mask", 32'(bus.done_mask), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    bus.start = 0; bus.core_en = '0; bus.core_done = '0; bus.clear_interrupt = 0;
    m_reset();
    #12 check_outputs();
    @(negedge clk);
    reset = 0;
    step(1, 4'b1111, '0, 0);
    for (int c = 1; c < 12; c++) step(0, 4'b0000, (c >= 4 && c <= 7) ? N'(1) << (c - 4) : '0, 0);
    step(1, 4'b0101, '0, 1);
    for (int c = 1; c < 12; c++) step(0, 4'b1111, (c == 5) ? 4'b0001 : (c == 7) ? 4'b0100 : '0, 0);
    step(1, 4'b0000, '0, 1);
    for (int c = 1; c < 4; c++) step(0, '0, '0, 0);
    step(1, 4'b0001, '0, 0);
    for (int c = 1; c < 8; c++) step(1, 4'b1111, 4'b1000, 0);
    step(0, '0, 4'b0001, 0);
    for (int c = 0; c < 6; c++) step(0, '0, '0, 1);
    step(1, 4'b1111, '0, 0);
    for (int c = 1; c < 24; c++) step(0, '0, (c == 6) ? 4'b1101 : '0, 0);
    step(0, '0, 4'b1111, 1);
    for (int c = 0; c < 4; c++) step(0, '0, '0, 0);
    step(1, 4'b0010, '0, 0);
    for (int c = 1; c < 8; c++) step(0, '0, '0, 0);
    mid_reset();
    step(1, 4'b1011, '0, 0);
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] d;
      d = N'($urandom & $urandom);
      step(($urandom_range(0, 2) == 0), N'($urandom), d, ($urandom_range(0, 3) == 0));
      if (c == 1000) mid_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/core_dispatch_scheduler.md
CORE_DISPATCH_SCHEDULER -- requirements
Module: core_dispatch_scheduler

Interface
REQ-001 SHALL have parameter CORE_NUM, default 4, the number of shader cores sequenced.
REQ-002 SHALL have parameter TIMEOUT, default 1024, the watchdog limit in clk cycles (16-bit counter).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a run request from the memory-mapped control block, sampled each cycle.
REQ-006 SHALL have port core_en, input, CORE_NUM, the per-core enable mask.
REQ-007 SHALL have port core_done, input, CORE_NUM, per-core completion pulses.
REQ-008 SHALL have port clear_interrupt, input, 1, the host acknowledge.
REQ-009 SHALL have port core_start, output, CORE_NUM, per-core one-cycle launch pulses.
REQ-010 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-011 SHALL have port interrupt, output, 1, the run-complete flag to the host (level).
REQ-012 SHALL have port done_mask, output, CORE_NUM, the cores that have completed in the current or last run.
REQ-013 SHALL have port timeout, output, 1, set when the watchdog aborted the last run.

Function
REQ-014 SHALL implement the states IDLE, DISPATCH, WAIT and DONE.
REQ-015 In IDLE, start=1 SHALL latch active_mask=core_en, clear done_mask and timeout, zero the slot index and enter DISPATCH next cycle.
REQ-016 start SHALL be ignored in any state other than IDLE, with no queuing.
REQ-017 If the latched active_mask==0, the block SHALL go IDLE->DONE directly and issue no core_start.
REQ-018 DISPATCH SHALL last exactly CORE_NUM cycles; in cycle i, core_start[i]=1 only if active_mask[i], and disabled slots still consume their cycle.
REQ-019 At most one core_start bit SHALL be high in any cycle.
REQ-020 After DISPATCH, the block SHALL enter WAIT.
REQ-021 core_done[i] SHALL set done_mask[i] only if active_mask[i] and core_start[i] was issued in an earlier cycle; all other done pulses are ignored.
REQ-022 A core_done[i] arriving while core i is still in DISPATCH and already launched SHALL be accepted.
REQ-023 When (done_mask & active_mask)==active_mask, from DISPATCH-end or WAIT, the block SHALL enter DONE next cycle.
REQ-024 DONE SHALL last one cycle, set interrupt=1, then return to IDLE.
REQ-025 interrupt SHALL hold until a cycle with clear_interrupt=1 and no DONE; if set and clear fall in the same cycle, set wins.
REQ-026 Changes to core_en during a run SHALL have no effect until the next start.
REQ-027 done_mask SHALL remain readable after the run until the next accepted start.

Reset
REQ-028 Asserting reset SHALL, asynchronously at any time including mid-run, force state=IDLE and clear core_start, busy, interrupt, done_mask, timeout, active_mask, the slot index and the watchdog counter.
REQ-029 After reset deasserts, the first start SHALL be accepted on the first clk edge.

Configuration
REQ-030 With SCHED_WATCHDOG_EN defined, the watchdog counter SHALL increment each cycle in DISPATCH and WAIT and clear on entry to DISPATCH.
REQ-031 With SCHED_WATCHDOG_EN defined, reaching TIMEOUT-1 SHALL set timeout=1 and enter DONE (interrupt raised), with done_mask holding the cores that did finish.
REQ-032 Without SCHED_WATCHDOG_EN, no counter SHALL exist, timeout SHALL be tied 0, and WAIT SHALL persist until all active cores are done or reset.

Verification
REQ-033 core_en=4'b1111, start pulse, done pulses 3 cycles after each launch -> core_start 0001,0010,0100,1000 on consecutive cycles, interrupt=1, done_mask=1111, busy low after DONE.
REQ-034 core_en=4'b0101 -> pulses only on bits 0 and 2, 4 DISPATCH cycles, done_mask=0101, interrupt after both done.
REQ-035 core_en=0, start -> no core_start, interrupt=1 two cycles after start.
REQ-036 start during WAIT plus spurious core_done[3] with active_mask=0001 -> run unchanged, done_mask=0001; clear_interrupt coincident with DONE -> interrupt stays 1, next clear -> 0.
REQ-037 SCHED_WATCHDOG_EN defined, TIMEOUT=16, core 1 never done -> timeout=1, interrupt=1, done_mask lacks bit 1; reset mid-WAIT -> all outputs 0 immediately.
